// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLLVR lock controller: state encoding,
// divider-select width and a small constant helper.
package pll_ctrl_pkg;

    localparam int DSEL_W = 6;

    typedef logic [2:0] pll_state_t;

    localparam pll_state_t ST_RESET_PLL = 3'd0;
    localparam pll_state_t ST_WAIT_LOCK = 3'd1;
    localparam pll_state_t ST_STABLE    = 3'd2;
    localparam pll_state_t ST_RUN       = 3'd3;
    localparam pll_state_t ST_FAULT     = 3'd4;

    // Largest of three elaboration-time constants; sizes the shared timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/pllvr_lock_ctrl.sv
// Gowin PLLVR sequencer: pulses the PLL reset, qualifies LOCK, releases the
// downstream core reset, retries on timeout and parks in FAULT after a bounded
// number of failed attempts. Divider codes are reloaded via valid/ready.
// Runs on the crystal reference clock, never on the PLL output.
module pllvr_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                RST_CYCLES    = 16,
    parameter int                LOCK_TIMEOUT  = 27000,
    parameter int                STABLE_CYCLES = 256,
    parameter int                MAX_RETRIES   = 3,
    parameter logic [DSEL_W-1:0] DEF_IDSEL     = 6'd0,
    parameter logic [DSEL_W-1:0] DEF_FBDSEL    = 6'd0,
    parameter logic [DSEL_W-1:0] DEF_ODSEL     = 6'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DSEL_W-1:0] cfg_idsel,
    input  logic [DSEL_W-1:0] cfg_fbdsel,
    input  logic [DSEL_W-1:0] cfg_odsel,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [DSEL_W-1:0] pll_idsel,
    output logic [DSEL_W-1:0] pll_fbdsel,
    output logic [DSEL_W-1:0] pll_odsel,
    output logic              core_rst,
    output logic              locked,
    output logic              fault,
    output logic [7:0]        relock_count
);

    localparam int TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam int FAIL_W  = $clog2(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0]  RST_LAST  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock_s counts as the first stable
    // cycle, so STABLE itself only needs STABLE_CYCLES-1 more of them.
    localparam logic [TMR_W-1:0]  STB_LAST  = TMR_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
    localparam bit                STB_SKIP  = (STABLE_CYCLES <= 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_RETRIES - 1);

    pll_state_t        state;
    pll_state_t        state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_nxt;
    logic [FAIL_W-1:0] fail_cnt;
    logic [FAIL_W-1:0] fail_nxt;
    logic              cfg_take;
    logic              relock_inc;
    logic              lock_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // State register plus the timer, retry count, divider codes and relock counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RESET_PLL;
            tmr          <= '0;
            fail_cnt     <= '0;
            relock_count <= 8'd0;
            pll_idsel    <= DEF_IDSEL;
            pll_fbdsel   <= DEF_FBDSEL;
            pll_odsel    <= DEF_ODSEL;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            fail_cnt <= fail_nxt;
            if (cfg_take) begin
                pll_idsel  <= cfg_idsel;
                pll_fbdsel <= cfg_fbdsel;
                pll_odsel  <= cfg_odsel;
            end
            if (relock_inc && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

    // Next-state logic; a cfg transfer overrides every other transition.
    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr;
        fail_nxt   = fail_cnt;
        cfg_take   = 1'b0;
        relock_inc = 1'b0;
        case (state)
            ST_RESET_PLL: begin
                if (tmr == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    tmr_nxt = '0;
                    if (STB_SKIP) begin
                        state_nxt = ST_RUN;
                        fail_nxt  = '0;
                    end else begin
                        state_nxt = ST_STABLE;
                    end
                end else if (tmr == TO_LAST) begin
                    tmr_nxt   = '0;
                    fail_nxt  = fail_cnt + FAIL_W'(1);
                    state_nxt = (fail_cnt == FAIL_LAST) ? ST_FAULT : ST_RESET_PLL;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    tmr_nxt   = '0;
                end else if (tmr == STB_LAST) begin
                    state_nxt = ST_RUN;
                    tmr_nxt   = '0;
                    fail_nxt  = '0;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (cfg_valid) begin
                    cfg_take = 1'b1;
                end else if (!lock_s) begin
                    state_nxt  = ST_RESET_PLL;
                    tmr_nxt    = '0;
                    relock_inc = 1'b1;
                end
            end
            ST_FAULT: begin
                if (cfg_valid) begin
                    cfg_take = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RESET_PLL;
                tmr_nxt   = '0;
            end
        endcase
        if (cfg_take) begin
            state_nxt = ST_RESET_PLL;
            tmr_nxt   = '0;
            fail_nxt  = '0;
        end
    end

    // Outputs decoded straight from the state register.
    always_comb begin
        pll_reset = (state == ST_RESET_PLL) || (state == ST_FAULT);
        core_rst  = (state != ST_RUN);
        locked    = (state == ST_RUN);
        fault     = (state == ST_FAULT);
        cfg_ready = (state == ST_RUN) || (state == ST_FAULT);
    end

endmodule

// File: tb/tb_pllvr_lock_ctrl.sv
// Self-checking bench for pllvr_lock_ctrl with short timing parameters.
module tb_pllvr_lock_ctrl;
    import pll_ctrl_pkg::*;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 3;
    localparam logic [5:0] DEF_ID = 6'h05;
    localparam logic [5:0] DEF_FB = 6'h0A;
    localparam logic [5:0] DEF_OD = 6'h03;

    typedef struct packed {
        logic [5:0] id;
        logic [5:0] fb;
        logic [5:0] od;
    } cfg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [5:0] cfg_idsel = 6'd0;
    logic [5:0] cfg_fbdsel = 6'd0;
    logic [5:0] cfg_odsel = 6'd0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       core_rst;
    logic       locked;
    logic       fault;
    logic [7:0] relock_count;

    cfg_t cfg_q[$];
    int   rel_q[$];
    int   errors = 0;
    int   checks = 0;

    pllvr_lock_ctrl #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .DEF_IDSEL     (DEF_ID),
        .DEF_FBDSEL    (DEF_FB),
        .DEF_ODSEL     (DEF_OD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_idsel    (cfg_idsel),
        .cfg_fbdsel   (cfg_fbdsel),
        .cfg_odsel    (cfg_odsel),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .pll_idsel    (pll_idsel),
        .pll_fbdsel   (pll_fbdsel),
        .pll_odsel    (pll_odsel),
        .core_rst     (core_rst),
        .locked       (locked),
        .fault        (fault),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return pll_reset;
            1:       return core_rst;
            2:       return locked;
            default: return fault;
        endcase
    endfunction

    // Ticks until the selected output equals lvl; n = ticks taken, -1 on expiry.
    task automatic wait_for(input int which, input logic lvl, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (sig_of(which) === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        pll_lock = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic bring_up();
        int n;
        do_reset();
        pll_lock = 1'b1;
        wait_for(2, 1'b1, 100, n);
        if (n < 0) begin
            errors++;
            $display("FAIL bring_up: locked never rose, got %0d required 1", locked);
        end
    endtask

    // Offers a divider set, records it in the scoreboard and returns right after the accept edge.
    task automatic cfg_send(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od, output bit ok);
        cfg_q.push_back({id, fb, od});
        cfg_idsel = id;
        cfg_fbdsel = fb;
        cfg_odsel = od;
        cfg_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cfg_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        cfg_t obs;
        rst = 1'b1;
        tick();
        obs = {pll_idsel, pll_fbdsel, pll_odsel};
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL rst_pll_reset: got %0d required 1", pll_reset); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %0d required 1", core_rst); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0d required 0", locked); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %0d required 0", fault); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready: got %0d required 0", cfg_ready); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL rst_relock: got %0d required 0", relock_count); end
        checks++; if (obs !== {DEF_ID, DEF_FB, DEF_OD}) begin errors++; $display("FAIL rst_dsel: got %h required %h", obs, {DEF_ID, DEF_FB, DEF_OD}); end
    endtask

    task automatic test_power_up();
        int n;
        rst = 1'b0;
        wait_for(0, 1'b0, 50, n);
        checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL pu_reset_width: got %0d required %0d", n, RST_CYCLES); end
        repeat (10) tick();
        pll_lock = 1'b1;
        wait_for(1, 1'b0, 100, n);
        checks++; if (n !== 2 + STABLE_CYCLES) begin errors++; $display("FAIL pu_lock_latency: got %0d required %0d", n, 2 + STABLE_CYCLES); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pu_locked: got %0d required 1", locked); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL pu_relock: got %0d required 0", relock_count); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL pu_cfg_ready: got %0d required 1", cfg_ready); end
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL pu_pll_reset: got %0d required 0", pll_reset); end
    endtask

    task automatic test_stable_glitch();
        int  n;
        bit  saw_prst;
        do_reset();
        wait_for(0, 1'b0, 50, n);
        pll_lock = 1'b1;
        repeat (4) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        n = 0;
        saw_prst = 1'b0;
        while (n < 100 && core_rst === 1'b1) begin
            tick();
            n++;
            if (pll_reset !== 1'b0) saw_prst = 1'b1;
        end
        checks++; if (n !== 2 + STABLE_CYCLES) begin errors++; $display("FAIL glitch_relock_latency: got %0d required %0d", n, 2 + STABLE_CYCLES); end
        checks++; if (saw_prst !== 1'b0) begin errors++; $display("FAIL glitch_pll_reset: got %0d required 0", saw_prst); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL glitch_locked: got %0d required 1", locked); end
    endtask

    task automatic test_timeout();
        int   n;
        bit   ok;
        cfg_t obs;
        cfg_t exp;
        do_reset();
        for (int i = 0; i < MAX_RETRIES; i++) begin
            wait_for(0, 1'b0, 50, n);
            checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL to_pulse_width[%0d]: got %0d required %0d", i, n, RST_CYCLES); end
            wait_for(0, 1'b1, 200, n);
            checks++; if (n !== LOCK_TIMEOUT) begin errors++; $display("FAIL to_spacing[%0d]: got %0d required %0d", i, n, LOCK_TIMEOUT); end
            checks++; if (fault !== (i == MAX_RETRIES - 1)) begin errors++; $display("FAIL to_fault[%0d]: got %0d required %0d", i, fault, i == MAX_RETRIES - 1); end
        end
        repeat (100) tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault_held: got %0d required 1", fault); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL to_cfg_ready: got %0d required 1", cfg_ready); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL to_pll_reset: got %0d required 1", pll_reset); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL to_core_rst: got %0d required 1", core_rst); end
        // Leave FAULT by a cfg transfer; the retry budget must restart from zero.
        cfg_send(6'h12, 6'h13, 6'h14, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fault_cfg_accept: got 0 required 1"); end
        obs = {pll_idsel, pll_fbdsel, pll_odsel};
        exp = cfg_q.pop_front();
        checks++; if (obs !== exp) begin errors++; $display("FAIL fault_cfg_dsel: got %h required %h", obs, exp); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_exit: got %0d required 0", fault); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL fault_exit_pll_reset: got %0d required 1", pll_reset); end
        wait_for(3, 1'b1, 400, n);
        checks++; if (n !== MAX_RETRIES * (RST_CYCLES + LOCK_TIMEOUT)) begin
            errors++; $display("FAIL fault_retry_budget: got %0d required %0d", n, MAX_RETRIES * (RST_CYCLES + LOCK_TIMEOUT));
        end
    endtask

    task automatic test_cfg_ignored();
        cfg_t obs;
        do_reset();
        repeat (6) tick();
        cfg_idsel = 6'h2A;
        cfg_fbdsel = 6'h2A;
        cfg_odsel = 6'h2A;
        cfg_valid = 1'b1;
        repeat (20) tick();
        obs = {pll_idsel, pll_fbdsel, pll_odsel};
        checks++; if (obs !== {DEF_ID, DEF_FB, DEF_OD}) begin errors++; $display("FAIL ign_dsel: got %h required %h", obs, {DEF_ID, DEF_FB, DEF_OD}); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ign_cfg_ready: got %0d required 0", cfg_ready); end
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL ign_pll_reset: got %0d required 0", pll_reset); end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reconfig();
        int   n;
        bit   ok;
        cfg_t obs;
        cfg_t exp;
        bring_up();
        cfg_send(6'h39, 6'h26, 6'h38, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rc_accept: got 0 required 1"); end
        obs = {pll_idsel, pll_fbdsel, pll_odsel};
        exp = cfg_q.pop_front();
        checks++; if (obs !== exp) begin errors++; $display("FAIL rc_dsel: got %h required %h", obs, exp); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rc_core_rst: got %0d required 1", core_rst); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL rc_pll_reset: got %0d required 1", pll_reset); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rc_cfg_ready: got %0d required 0", cfg_ready); end
        wait_for(1, 1'b0, 100, n);
        checks++; if (n !== RST_CYCLES + STABLE_CYCLES) begin errors++; $display("FAIL rc_relock_latency: got %0d required %0d", n, RST_CYCLES + STABLE_CYCLES); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL rc_relock: got %0d required 0", relock_count); end
        obs = {pll_idsel, pll_fbdsel, pll_odsel};
        checks++; if (obs !== exp) begin errors++; $display("FAIL rc_dsel_held: got %h required %h", obs, exp); end
    endtask

    task automatic test_same_cycle();
        int   n;
        bit   ok;
        cfg_t obs;
        cfg_t exp;
        bring_up();
        pll_lock = 1'b0;
        tick();
        tick();
        cfg_send(6'h01, 6'h02, 6'h04, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sc_accept: got 0 required 1"); end
        obs = {pll_idsel, pll_fbdsel, pll_odsel};
        exp = cfg_q.pop_front();
        checks++; if (obs !== exp) begin errors++; $display("FAIL sc_dsel: got %h required %h", obs, exp); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL sc_relock: got %0d required 0", relock_count); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL sc_core_rst: got %0d required 1", core_rst); end
        pll_lock = 1'b1;
        wait_for(2, 1'b1, 100, n);
        checks++; if (n < 0) begin errors++; $display("FAIL sc_relock_run: got %0d required 1", locked); end
    endtask

    task automatic test_lock_loss();
        int n;
        int exp;
        bring_up();
        pll_lock = 1'b0;
        rel_q.push_back(1);
        tick();
        tick();
        checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL ll_early: got %0d required 0", core_rst); end
        tick();
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL ll_core_rst: got %0d required 1", core_rst); end
        exp = rel_q.pop_front();
        checks++; if (relock_count !== 8'(exp)) begin errors++; $display("FAIL ll_relock: got %0d required %0d", relock_count, exp); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ll_locked: got %0d required 0", locked); end
        pll_lock = 1'b1;
        wait_for(2, 1'b1, 100, n);
        // Repeated lock losses drive the counter into saturation.
        for (int k = 2; k <= 258; k++) begin
            pll_lock = 1'b0;
            rel_q.push_back((k > 255) ? 255 : k);
            wait_for(1, 1'b1, 20, n);
            exp = rel_q.pop_front();
            checks++; if (n !== 3 || relock_count !== 8'(exp)) begin
                errors++; $display("FAIL ll_sat[%0d]: got n=%0d relock=%0d required n=3 relock=%0d", k, n, relock_count, exp);
            end
            pll_lock = 1'b1;
            wait_for(2, 1'b1, 100, n);
            if (n < 0) begin
                errors++; $display("FAIL ll_sat_relock[%0d]: got locked=%0d required 1", k, locked);
                break;
            end
        end
    endtask

    task automatic test_async_rst();
        int   n;
        bit   ok;
        cfg_t obs;
        cfg_t exp;
        checks++; if (relock_count !== 8'd255) begin errors++; $display("FAIL ar_pre_relock: got %0d required 255", relock_count); end
        pll_lock = 1'b0;
        cfg_send(6'h3F, 6'h3E, 6'h3D, ok);
        obs = {pll_idsel, pll_fbdsel, pll_odsel};
        exp = cfg_q.pop_front();
        checks++; if (!ok || obs !== exp) begin errors++; $display("FAIL ar_cfg: got %h required %h", obs, exp); end
        wait_for(0, 1'b0, 50, n);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        obs = {pll_idsel, pll_fbdsel, pll_odsel};
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL ar_pll_reset: got %0d required 1", pll_reset); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL ar_core_rst: got %0d required 1", core_rst); end
        checks++; if (locked !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL ar_flags: got %0d%0d required 00", locked, fault); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ar_cfg_ready: got %0d required 0", cfg_ready); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL ar_relock: got %0d required 0", relock_count); end
        checks++; if (obs !== {DEF_ID, DEF_FB, DEF_OD}) begin errors++; $display("FAIL ar_dsel: got %h required %h", obs, {DEF_ID, DEF_FB, DEF_OD}); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_stable_glitch();
        test_timeout();
        test_cfg_ignored();
        test_reconfig();
        test_same_cycle();
        test_lock_loss();
        test_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no completion required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
